mult_mem_engine: RTL

// Parametrised memory-backed sequential multiplier. It fetches two operands from an

---
 rtl/mult_mem_engine.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mult_mem_engine.sv
// Memory-backed shift-add multiplier: fetches two operands from an internal register
// file, multiplies them (signed or unsigned), and writes the product back and to o_result.
module mult_mem_engine #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr_en,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [2*DATA_W-1:0]   i_wr_data,
    input  logic                  i_start,
    input  logic                  i_signed_mode,
    input  logic [ADDR_W-1:0]     i_addr1,
    input  logic [ADDR_W-1:0]     i_addr2,
    input  logic [ADDR_W-1:0]     i_addr3,
    output logic [2*DATA_W-1:0]   o_result,
    output logic [2:0]            o_st_out,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_MULT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [PROD_W-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_addr1;
    logic [ADDR_W-1:0]   r_addr2;
    logic [ADDR_W-1:0]   r_addr3;
    logic                r_signed;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic                r_neg;
    logic [PROD_W-1:0]   r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [PROD_W-1:0]   r_result;
    logic                r_busy;
    logic                r_done;

    logic [DATA_W-1:0]   w_op_a;
    logic [DATA_W-1:0]   w_op_b;
    logic                w_sign_a;
    logic                w_sign_b;
    logic [DATA_W-1:0]   w_mag_a;
    logic [DATA_W-1:0]   w_mag_b;
    logic [PROD_W-1:0]   w_addend;
    logic [PROD_W-1:0]   w_prod;
    logic                w_host_wr;
    logic                w_last;

    assign w_op_a   = r_mem[r_addr1][DATA_W-1:0];
    assign w_op_b   = r_mem[r_addr2][DATA_W-1:0];
    assign w_sign_a = r_signed & w_op_a[DATA_W-1];
    assign w_sign_b = r_signed & w_op_b[DATA_W-1];
    // Magnitude of the most negative value still fits as an unsigned DATA_W word.
    assign w_mag_a  = w_sign_a ? DATA_W'(~w_op_a + DATA_W'(1)) : w_op_a;
    assign w_mag_b  = w_sign_b ? DATA_W'(~w_op_b + DATA_W'(1)) : w_op_b;
    assign w_addend = PROD_W'(r_a) << r_cnt;
    assign w_prod   = r_neg ? PROD_W'(~r_acc + PROD_W'(1)) : r_acc;
    assign w_host_wr = i_wr_en && (r_state == ST_IDLE);
    assign w_last   = (r_cnt == CNT_W'(DATA_W - 1));

    assign o_result = r_result;
    assign o_st_out = r_state;
    assign o_busy   = r_busy;
    assign o_done   = r_done;

    // State register with registered busy/done decoded from the next state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (w_next == ST_DONE);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_next = ST_FETCH;
            ST_FETCH: w_next = ST_MULT;
            ST_MULT:  if (w_last) w_next = ST_WRITE;
            ST_WRITE: w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Operand capture, shift-add accumulation and result register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr1  <= '0;
            r_addr2  <= '0;
            r_addr3  <= '0;
            r_signed <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_addr1  <= i_addr1;
                        r_addr2  <= i_addr2;
                        r_addr3  <= i_addr3;
                        r_signed <= i_signed_mode;
                    end
                end
                ST_FETCH: begin
                    r_a   <= w_mag_a;
                    r_b   <= w_mag_b;
                    r_neg <= w_sign_a ^ w_sign_b;
                    r_acc <= '0;
                    r_cnt <= '0;
                end
                ST_MULT: begin
                    if (r_b[r_cnt]) r_acc <= r_acc + w_addend;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                ST_WRITE: r_result <= w_prod;
                default: ;
            endcase
        end
    end

    // Register file: not cleared by reset; host port only while idle.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (w_host_wr) begin
                r_mem[i_wr_addr] <= i_wr_data;
            end else if (r_state == ST_WRITE) begin
                r_mem[r_addr3] <= w_prod;
            end
        end
    end

endmodule
